// File: rtl/pipelined_shifter.sv
// Two-stage barrel shifter (LSL/LSR/ASR/ROR) with valid/ready handshake.
// Define SHIFTER_ROR_EN to build the rotate path; otherwise ShOp=11 passes ShIn.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] ShIn,
    input  logic [SHW-1:0]   Shamt,
    input  logic [1:0]       ShOp,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ShOut,
    output logic             ShCarry,
    output logic             ShZero
);

    localparam int LO = SHW / 2;
    localparam int HI = SHW - LO;
    localparam logic [SHW-1:0] ONE = SHW'(1);

    logic             adv;
    logic             ld1, ld2;
    logic [SHW-1:0]   amt_hi, lidx, ridx, lo_amt;
    logic [WIDTH-1:0] sh1, res2;
    logic             c1, c2;

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] d1_q, d1_d;
    logic [LO-1:0]    lo1_q, lo1_d;
    logic [1:0]       op1_q, op1_d;
    logic             c1_q, c1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c2_q, c2_d;
    logic             z2_q, z2_d;

`ifdef SHIFTER_ROR_EN
    logic [2*WIDTH-1:0] rot1, rot2;
    logic               nz1_q, nz1_d;
`endif

    assign adv     = !v2_q | OutReady;
    assign InReady = adv;
    assign ld1     = !Flush & adv & InValid;
    assign ld2     = !Flush & adv & v1_q;

    // Stage 1: upper shift-amount bits, plus carry from the raw operand
    always_comb begin
        amt_hi = {Shamt[SHW-1:LO], {LO{1'b0}}};
        lidx   = -Shamt;
        ridx   = Shamt - ONE;
        sh1    = ShIn;
        c1     = 1'b0;
`ifdef SHIFTER_ROR_EN
        rot1   = {ShIn, ShIn} >> amt_hi;
`endif
        unique case (ShOp)
            2'b00: begin
                sh1 = ShIn << amt_hi;
                c1  = ShIn[lidx];
            end
            2'b01: begin
                sh1 = ShIn >> amt_hi;
                c1  = ShIn[ridx];
            end
            2'b10: begin
                sh1 = $signed(ShIn) >>> amt_hi;
                c1  = ShIn[ridx];
            end
            default: begin
`ifdef SHIFTER_ROR_EN
                sh1 = rot1[WIDTH-1:0];
`else
                sh1 = ShIn;
`endif
                c1  = 1'b0;
            end
        endcase
        if (Shamt == '0) c1 = 1'b0;
    end

    // Stage 2: remaining lower shift-amount bits
    always_comb begin
        lo_amt = {{HI{1'b0}}, lo1_q};
        res2   = d1_q;
        c2     = c1_q;
`ifdef SHIFTER_ROR_EN
        rot2   = {d1_q, d1_q} >> lo_amt;
`endif
        unique case (op1_q)
            2'b00:   res2 = d1_q << lo_amt;
            2'b01:   res2 = d1_q >> lo_amt;
            2'b10:   res2 = $signed(d1_q) >>> lo_amt;
            default: begin
`ifdef SHIFTER_ROR_EN
                res2 = rot2[WIDTH-1:0];
                c2   = nz1_q & res2[WIDTH-1];
`else
                res2 = d1_q;
`endif
            end
        endcase
    end

    always_comb begin
        v1_d  = Flush ? 1'b0 : (adv ? InValid : v1_q);
        v2_d  = Flush ? 1'b0 : (adv ? v1_q : v2_q);
        d1_d  = ld1 ? sh1 : d1_q;
        lo1_d = ld1 ? Shamt[LO-1:0] : lo1_q;
        op1_d = ld1 ? ShOp : op1_q;
        c1_d  = ld1 ? c1 : c1_q;
        out_d = ld2 ? res2 : out_q;
        c2_d  = ld2 ? c2 : c2_q;
        z2_d  = ld2 ? (res2 == '0) : z2_q;
`ifdef SHIFTER_ROR_EN
        nz1_d = ld1 ? (Shamt != '0) : nz1_q;
`endif
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            lo1_q <= '0;
            op1_q <= '0;
            c1_q  <= 1'b0;
            v2_q  <= 1'b0;
            out_q <= '0;
            c2_q  <= 1'b0;
            z2_q  <= 1'b0;
`ifdef SHIFTER_ROR_EN
            nz1_q <= 1'b0;
`endif
        end else begin
            v1_q  <= v1_d;
            d1_q  <= d1_d;
            lo1_q <= lo1_d;
            op1_q <= op1_d;
            c1_q  <= c1_d;
            v2_q  <= v2_d;
            out_q <= out_d;
            c2_q  <= c2_d;
            z2_q  <= z2_d;
`ifdef SHIFTER_ROR_EN
            nz1_q <= nz1_d;
`endif
        end
    end

    assign OutValid = v2_q;
    assign ShOut    = out_q;
    assign ShCarry  = c2_q;
    assign ShZero   = z2_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: random and directed shifts,
// backpressure, flush and reset-in-flight.
module tb_pipelined_shifter;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] ShIn = '0;
    logic [4:0]  Shamt = '0;
    logic [1:0]  ShOp = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] ShOut;
    logic        ShCarry;
    logic        ShZero;

    pipelined_shifter #(.WIDTH(32)) dut (
        .CLK(CLK), .RESETn(RESETn), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .ShIn(ShIn), .Shamt(Shamt), .ShOp(ShOp),
        .OutValid(OutValid), .OutReady(OutReady),
        .ShOut(ShOut), .ShCarry(ShCarry), .ShZero(ShZero)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass = 0;
    logic [33:0] exp_q[$];
    bit rand_rdy = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: {zero, carry, out} from the operation definitions
    function automatic logic [33:0] model(logic [31:0] d, int n, logic [1:0] op);
        logic [31:0] o;
        logic c;
        o = d;
        c = 1'b0;
        case (op)
            2'b00: begin
                o = d << n;
                if (n > 0) c = d[32-n];
            end
            2'b01: begin
                o = d >> n;
                if (n > 0) c = d[n-1];
            end
            2'b10: begin
                o = d >> n;
                if (d[31]) o = o | ~(32'hFFFF_FFFF >> n);
                if (n > 0) c = d[n-1];
            end
            default: begin
`ifdef SHIFTER_ROR_EN
                if (n > 0) begin
                    o = (d >> n) | (d << (32 - n));
                    c = o[31];
                end
`endif
            end
        endcase
        return {(o == 32'd0), c, o};
    endfunction

    // Monitor / scoreboard
    always @(negedge CLK) begin
        logic [33:0] e;
        if (!RESETn) begin
            exp_q.delete();
            check("rst_outvalid", OutValid, 0);
            check("rst_shout", ShOut, 0);
            check("rst_carry", ShCarry, 0);
            check("rst_zero", ShZero, 0);
            check("rst_inready", InReady, 1);
        end else if (Flush) begin
            exp_q.delete();
        end else begin
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", OutValid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("shout", ShOut, e[31:0]);
                    check("carry", ShCarry, e[32]);
                    check("zero", ShZero, e[33]);
                end
            end
            if (InValid && InReady)
                exp_q.push_back(model(ShIn, int'(Shamt), ShOp));
        end
    end

    always @(posedge CLK) begin
        if (rand_rdy) begin
            #2;
            OutReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(logic [31:0] d, int n, logic [1:0] op);
        bit ok;
        ok = 0;
        InValid = 1'b1;
        ShIn = d;
        Shamt = 5'(n);
        ShOp = op;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            ok = InReady;
            @(posedge CLK);
            #1;
            if (ok) break;
        end
        InValid = 1'b0;
        if (!ok) check("send_timeout", InReady, 1);
    endtask

    task automatic dir(string name, logic [31:0] d, int n, logic [1:0] op,
                       logic [31:0] eo, logic ec, logic ez);
        send(d, n, op);
        check({name, "_lat1"}, OutValid, 0);
        @(posedge CLK);
        #1;
        check({name, "_lat2"}, OutValid, 1);
        check({name, "_out"}, ShOut, eo);
        check({name, "_carry"}, ShCarry, ec);
        check({name, "_zero"}, ShZero, ez);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !OutValid) break;
            @(posedge CLK);
            #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESETn = 1'b1;

        dir("asr", 32'h8000_0000, 4, 2'b10, 32'hF800_0000, 1'b0, 1'b0);
        dir("lsl", 32'h0000_0001, 31, 2'b00, 32'h8000_0000, 1'b0, 1'b0);
        dir("lsr", 32'h8000_0003, 1, 2'b01, 32'h4000_0001, 1'b1, 1'b0);
`ifdef SHIFTER_ROR_EN
        dir("ror", 32'h1234_5678, 8, 2'b11, 32'h7812_3456, 1'b0, 1'b0);
        dir("ror1", 32'h0000_0001, 1, 2'b11, 32'h8000_0000, 1'b1, 1'b0);
`else
        dir("ror", 32'h1234_5678, 8, 2'b11, 32'h1234_5678, 1'b0, 1'b0);
`endif
        dir("zero", 32'h0, 0, 2'b00, 32'h0, 1'b0, 1'b1);
        dir("lsl0", 32'hFFFF_FFFF, 0, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0);
        dir("lslc", 32'h4000_0000, 2, 2'b00, 32'h0, 1'b1, 1'b1);
        drain();

        // Backpressure
        OutReady = 1'b0;
        send(32'h1, 1, 2'b00);
        send(32'h2, 1, 2'b00);
        InValid = 1'b1;
        ShIn = 32'h3;
        repeat (3) begin
            @(negedge CLK);
            check("bp_inready", InReady, 0);
            check("bp_hold", OutValid, 1);
        end
        @(posedge CLK);
        #1;
        OutReady = 1'b1;
        send(32'h3, 1, 2'b00);
        drain();

        // Flush with two in flight
        OutReady = 1'b0;
        send(32'hA5A5_0001, 3, 2'b01);
        send(32'hA5A5_0002, 3, 2'b01);
        Flush = 1'b1;
        InValid = 1'b1;
        @(posedge CLK);
        #1;
        Flush = 1'b0;
        InValid = 1'b0;
        check("flush_outvalid", OutValid, 0);
        OutReady = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("flush_quiet", OutValid, 0);

        // Reset with two in flight
        OutReady = 1'b0;
        send(32'h5A5A_0001, 5, 2'b10);
        send(32'h5A5A_0002, 5, 2'b10);
        RESETn = 1'b0;
        #1;
        check("rst_async", OutValid, 0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        OutReady = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("rst_quiet", OutValid, 0);

        // Random traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i % 17 == 0) d = 32'h0;
            if (i % 13 == 0) d = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge CLK);
                #1;
            end
            send(d, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        rand_rdy = 0;
        @(posedge CLK);
        #3;
        OutReady = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8 to 64 inclusive.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RESETn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Flush  input  1  synchronous pipeline clear.
REQ-006 InValid  input  1  request valid.
REQ-007 InReady  output  1  request accepted when InValid and InReady are both high on an edge.
REQ-008 ShIn  input  WIDTH  operand.
REQ-009 Shamt  input  SHW  shift amount, 0 to WIDTH-1.
REQ-010 ShOp  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 OutValid  output  1  result valid.
REQ-012 OutReady  input  1  result consumed when OutValid and OutReady are both high on an edge.
REQ-013 ShOut  output  WIDTH  shifted result.
REQ-014 ShCarry  output  1  last bit shifted out.
REQ-015 ShZero  output  1  high when ShOut is all zeros.

Function
REQ-016 Two register stages, S1 and S2; S2 drives ShOut, ShCarry, ShZero and OutValid directly from flops.
REQ-017 S1 SHALL apply the upper ceil(SHW/2) bits of Shamt as a logarithmic shift; S2 SHALL apply the remaining lower bits.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to OutValid high, with no stall.
REQ-019 Throughput SHALL be 1 result per cycle.
REQ-020 Advance = !OutValid | OutReady; InReady = Advance.
REQ-021 When Advance is low, S1 and S2 (data and valid) SHALL hold.
REQ-022 LSL and LSR SHALL zero-fill.
REQ-023 ASR SHALL fill with ShIn[WIDTH-1].
REQ-024 ROR SHALL rotate right.
REQ-025 ShCarry for Shamt=n>0:
  - LSL: ShIn[WIDTH-n]
  - LSR/ASR: ShIn[n-1]
  - ROR: ShOut[WIDTH-1]
REQ-026 ShCarry for Shamt=0: 0 for every op; ShOut = ShIn.
REQ-027 ShCarry for LSL/LSR/ASR SHALL be computed in S1 from the unshifted operand and carried through S2.
REQ-028 Results SHALL emerge in acceptance order, none dropped or duplicated.
REQ-029 Flush high on an edge clears S1 and S2 valids and ignores InValid that cycle; Flush takes priority over acceptance and stall.
REQ-030 Data registers SHALL load only when their stage captures a valid entry.

Reset
REQ-031 While RESETn is low, all valids, ShOut, ShCarry and ShZero SHALL be 0, asynchronously.
REQ-032 InReady SHALL be 1 during reset.
REQ-033 Operations in flight at reset assertion SHALL be discarded and never output.
REQ-034 The first acceptance SHALL be possible on the first edge after RESETn deasserts.

Configuration
REQ-035 Macro SHIFTER_ROR_EN defined: ShOp=11 performs ROR per REQ-024 and REQ-025.
REQ-036 Macro SHIFTER_ROR_EN undefined: ShOp=11 returns ShOut=ShIn and ShCarry=0, and no rotate logic is synthesised; all other ops are unchanged.

Verification
REQ-037 ASR: ShIn=0x80000000, Shamt=4 -> ShOut=0xF8000000, ShCarry=0, OutValid exactly 2 edges after acceptance.
REQ-038 LSL: 0x00000001 by 31 -> 0x80000000, carry 0; LSR: 0x80000003 by 1 -> 0x40000001, carry 1.
REQ-039 ROR: 0x12345678 by 8 -> 0x78123456, carry 0 with SHIFTER_ROR_EN; 0x12345678, carry 0 without it.
REQ-040 Backpressure: issue 0x1, 0x2, 0x3 (LSL by 1) back-to-back with OutReady low for 3 cycles -> InReady low while held; outputs 0x2, 0x4, 0x6 in order after release.
REQ-041 Reset/flush: RESETn pulsed low with 2 in flight -> OutValid 0 immediately and no outputs after release; repeat with Flush -> same.
REQ-042 Zero: ShIn=0, Shamt=0 -> ShOut=0, ShZero=1, ShCarry=0.
